// File: rtl/boid_step_scheduler.sv
// boid_step_scheduler: sequences the pair-interaction and per-boid update passes of one boid simulation step
module boid_step_scheduler #(
  parameter int N_BOIDS = 8,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [IDX_W-1:0] pair_i,
  output logic [IDX_W-1:0] pair_j,
  output logic             pair_last,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_idx,
  output logic [CNT_W-1:0] step_count,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, PAIR, UPDATE, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_BOIDS - 1);
  localparam logic [IDX_W-1:0] LAST2 = IDX_W'(N_BOIDS > 1 ? N_BOIDS - 2 : 0);
  state_t state, state_n;
  logic [IDX_W-1:0] i_n, j_n, j_inc;
  logic last_n;
  // next-state, next-index and next-pair_last; pair_i/pair_j double as the i/j registers
  always_comb begin
    state_n = state;
    i_n = pair_i;
    j_n = pair_j;
    j_inc = pair_j + IDX_W'(1);
    case (state)
      IDLE: if (en) begin
        i_n = '0;
        j_n = IDX_W'(1);
        state_n = (N_BOIDS == 1) ? UPDATE : PAIR;
      end
      PAIR: if (pair_ready) begin
        state_n = pair_last ? UPDATE : PAIR;
        j_n = pair_last ? pair_j : ((j_inc == pair_i) ? j_inc + IDX_W'(1) : j_inc);
      end
      UPDATE: if (upd_ready) begin
        if (pair_i == LAST) state_n = DONE;
        else begin
          i_n = pair_i + IDX_W'(1);
          j_n = (i_n == '0) ? IDX_W'(1) : '0;
          state_n = PAIR;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    last_n = (state_n == PAIR) && (j_n == ((i_n == LAST) ? LAST2 : LAST));
  end
  // state and all outputs registered from the next-state decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pair_valid <= 1'b0;
      upd_valid <= 1'b0;
      pair_last <= 1'b0;
      pair_i <= '0;
      pair_j <= '0;
      upd_idx <= '0;
      step_count <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      pair_valid <= state_n == PAIR;
      upd_valid <= state_n == UPDATE;
      pair_last <= last_n;
      pair_i <= i_n;
      pair_j <= j_n;
      upd_idx <= i_n;
      step_count <= step_count + CNT_W'(state_n == DONE);
      overrun <= overrun | (en && state != IDLE);
    end
  end
endmodule

// File: tb/tb_boid_step_scheduler.sv
// tb_boid_step_scheduler: directed and randomized checks of the step scheduler against a transaction-list model
module tb_boid_step_scheduler;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, pr = 1'b0, ur = 1'b0, sel = 1'b0;
  logic busy8, done8, pv8, last8, uv8, ov8, busy1, done1, pv1, last1, uv1, ov1;
  logic [2:0] pi8, pj8, ui8;
  logic [0:0] pi1, pj1, ui1;
  logic [1:0] cnt8;
  logic [15:0] cnt1;
  logic o_busy, o_done, o_pv, o_last, o_uv, o_ov, o_any;
  logic [7:0] o_pi, o_pj, o_ui;
  logic [15:0] o_cnt;
  int n_vec = 0, n_err = 0, done_cyc, stalled, cnt_exp;
  bit ov_exp;
  typedef struct {bit upd; int i; int j; bit last;} txn_t;

  always #5 clk = ~clk;

  boid_step_scheduler #(.N_BOIDS(8), .IDX_W(3), .CNT_W(2)) u8 (
    .clk(clk), .reset(reset), .en(en), .busy(busy8), .done(done8),
    .pair_valid(pv8), .pair_ready(pr), .pair_i(pi8), .pair_j(pj8), .pair_last(last8),
    .upd_valid(uv8), .upd_ready(ur), .upd_idx(ui8), .step_count(cnt8), .overrun(ov8));

  boid_step_scheduler #(.N_BOIDS(1), .IDX_W(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .en(en), .busy(busy1), .done(done1),
    .pair_valid(pv1), .pair_ready(pr), .pair_i(pi1), .pair_j(pj1), .pair_last(last1),
    .upd_valid(uv1), .upd_ready(ur), .upd_idx(ui1), .step_count(cnt1), .overrun(ov1));

  assign o_busy = sel ? busy1 : busy8;
  assign o_done = sel ? done1 : done8;
  assign o_pv   = sel ? pv1 : pv8;
  assign o_last = sel ? last1 : last8;
  assign o_uv   = sel ? uv1 : uv8;
  assign o_ov   = sel ? ov1 : ov8;
  assign o_pi   = sel ? {7'b0, pi1} : {5'b0, pi8};
  assign o_pj   = sel ? {7'b0, pj1} : {5'b0, pj8};
  assign o_ui   = sel ? {7'b0, ui1} : {5'b0, ui8};
  assign o_cnt  = sel ? cnt1 : {14'b0, cnt8};
  assign o_any  = |{o_busy, o_done, o_pv, o_last, o_uv, o_ov, o_pi, o_pj, o_ui, o_cnt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0; en = 1'b0; pr = 1'b0; ur = 1'b0;
    ov_exp = 1'b0; cnt_exp = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", o_any, 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // rnd: random readys; pace: en strobe period (0 = single strobe);
  // (st_i,st_j): pair whose ready is withheld 3 cycles; abort_upd: boid whose update is hit by reset
  task automatic run_step(input bit rnd, input int pace, input int st_i, input int st_j, input int abort_upd);
    txn_t q[$];
    int n = sel ? 1 : 8;
    int modv = sel ? 65536 : 4;
    int dones = 0;
    for (int a = 0; a < n; a++) begin
      int mx = -1;
      for (int b = 0; b < n; b++) if (b != a) mx = b;
      for (int b = 0; b < n; b++) if (b != a) q.push_back('{upd: 1'b0, i: a, j: b, last: (b == mx)});
      q.push_back('{upd: 1'b1, i: a, j: 0, last: 1'b0});
    end
    done_cyc = -1;
    stalled = 0;
    en = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      chk("dual_valid", o_pv & o_uv, 0);
      chk("overrun", o_ov, ov_exp);
      if (c == 1) begin
        chk("busy_start", o_busy, 1);
        chk("pv_start", o_pv, n > 1);
        chk("uv_start", o_uv, n == 1);
      end
      if (done_cyc > 0) begin
        chk("idle_after_done", {o_busy, o_done}, 0);
        break;
      end
      if (o_pv) begin
        if (q.size() == 0 || q[0].upd) chk("pair_order", 0, 1);
        else begin
          chk("pair_i", o_pi, q[0].i);
          chk("pair_j", o_pj, q[0].j);
          chk("pair_last", o_last, q[0].last);
        end
      end
      if (o_uv) begin
        if (q.size() == 0 || !q[0].upd) chk("upd_order", 0, 1);
        else chk("upd_idx", o_ui, q[0].i);
        if (o_ui == 8'(abort_upd)) begin
          reset = 1'b0;
          #1;
          chk("abort_zero", o_any, 0);
          ov_exp = 1'b0;
          cnt_exp = 0;
          en = 1'b0;
          @(negedge clk);
          chk("abort_no_done", o_any, 0);
          reset = 1'b1;
          return;
        end
      end
      if (o_pv && o_pi == 8'(st_i) && o_pj == 8'(st_j) && stalled < 3) begin
        pr = 1'b0;
        stalled++;
      end else pr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ur = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (((o_pv && pr) || (o_uv && ur)) && q.size() > 0) void'(q.pop_front());
      if (o_done) begin
        dones++;
        done_cyc = c;
        cnt_exp = (cnt_exp + 1) % modv;
        chk("queue_drained", q.size(), 0);
      end
      chk("step_count", o_cnt, cnt_exp);
      en = (pace > 0) && (c % pace == 0) && (done_cyc < 0);
      if (en) ov_exp = 1'b1;
    end
    chk("done_seen", done_cyc > 0, 1);
    chk("one_done", dones, 1);
  endtask

  initial begin
    int seqv[5];
    seqv = '{1, 2, 3, 0, 1};
    sel = 1'b0;
    do_reset();
    run_step(1'b0, 0, -1, -1, -1);
    chk("t1_done_cyc", done_cyc, 65);
    chk("t1_count", o_cnt, 1);
    run_step(1'b0, 0, 2, 5, -1);
    chk("t2_stall_cycles", stalled, 3);
    chk("t2_done_cyc", done_cyc, 68);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_step(1'b1, 0, -1, -1, -1);
      chk("cnt_seq", o_cnt, seqv[k]);
    end
    do_reset();
    run_step(1'b0, 5, -1, -1, -1);
    chk("pace_done_cyc", done_cyc, 65);
    chk("pace_overrun", o_ov, 1);
    do_reset();
    run_step(1'b1, 0, -1, -1, 4);
    chk("abort_count", o_cnt, 0);
    run_step(1'b0, 0, -1, -1, -1);
    chk("restart_done_cyc", done_cyc, 65);
    chk("restart_count", o_cnt, 1);
    sel = 1'b1;
    do_reset();
    run_step(1'b0, 0, -1, -1, -1);
    chk("n1_done_cyc", done_cyc, 2);
    run_step(1'b1, 0, -1, -1, -1);
    chk("n1_count", o_cnt, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/boid_step_scheduler.md
Name: boid_step_scheduler

Overview:
- Sequences one simulation step of the boid accelerator datapath.
- On each `en` strobe it walks every ordered pair (i, j) with i != j through a pair-interaction stage, then issues one per-boid update, boid by boid.
- It sits between the frame/step timing logic that produces `en` and the shared fix15 pair and update datapaths (distance via alpha-max-beta-min, fix15_mul scaling).
- Its handshakes let the datapaths be multi-cycle or pipelined.

Parameters:
- N_BOIDS, default 8: number of boids; legal range 1..256.
- IDX_W, default 3: index width; must equal max(1, clog2(N_BOIDS)).
- CNT_W, default 16: width of step_count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  step start strobe; sampled each cycle.
- busy  out  1  high while a step is in progress.
- done  out  1  one-cycle pulse at step completion.
- pair_valid  out  1  pair request valid.
- pair_ready  in  1  pair datapath accepts request.
- pair_i  out  IDX_W  index of boid being updated.
- pair_j  out  IDX_W  index of neighbour boid.
- pair_last  out  1  current pair is the last j for this i.
- upd_valid  out  1  update request valid for boid upd_idx.
- upd_ready  in  1  update datapath accepts.
- upd_idx  out  IDX_W  boid to integrate/write back.
- step_count  out  CNT_W  completed steps, wraps modulo 2^CNT_W.
- overrun  out  1  sticky; set when `en` arrives while busy.

Behaviour:
- Reset (reset low, asynchronous): state IDLE. busy, done, pair_valid, upd_valid, pair_last, overrun = 0. pair_i, pair_j, upd_idx, step_count = 0. Reset mid-step abandons the step immediately: valids drop without a handshake and no done pulse is produced.
- All outputs are registered.
- FSM states: IDLE, PAIR, UPDATE, DONE. busy = (state != IDLE).
- IDLE, en=1:
  - i <= 0; j <= first legal index (1, since i=0).
  - Next state PAIR, or UPDATE when N_BOIDS == 1.
  - Latency: en high at edge k gives pair_valid high in cycle k+1.
- PAIR:
  - pair_valid = 1. pair_i, pair_j and pair_last are held stable until pair_valid && pair_ready.
  - On a handshake, j advances to the next index skipping j == i.
  - If the accepted pair had pair_last = 1, the next state is UPDATE.
  - pair_last = 1 when j is the highest index != i: N_BOIDS-1, or N_BOIDS-2 when i == N_BOIDS-1.
- UPDATE:
  - upd_valid = 1; upd_idx = i, held until upd_ready.
  - On a handshake with i == N_BOIDS-1, the next state is DONE.
  - Otherwise i <= i+1; j <= first index != i+1 (0, or 1 if i+1 == 0); next state PAIR.
- DONE: done = 1 for exactly one cycle; step_count increments; next state IDLE.
- pair_valid and upd_valid are never high together.
- Valid never deasserts without a handshake, except on reset.
- Ready while valid is low is ignored.
- en while busy (PAIR, UPDATE or DONE) is ignored and sets overrun. overrun is cleared only by reset.
- en in IDLE in the cycle after DONE starts a new step normally.
- Throughput with both readys tied high: N*(N-1) pair cycles + N update cycles + 1 DONE cycle. For N=8 this is 56 + 8 + 1 = 65 busy cycles.
- Index arithmetic is unsigned IDX_W bits; i and j never exceed N_BOIDS-1.

Test Plan:
- N=8, readys tied 1, en pulse at cycle 0:
  - pairs are (0,1)..(0,7), upd 0, (1,0),(1,2)..(1,7), upd 1, …, (7,0)..(7,6), upd 7.
  - 56 pair handshakes and 8 updates; pair_last on (0,7), (1,7), …, (7,6).
  - done pulses at cycle 65; step_count = 1.
- pair_ready held low 3 cycles on pair (2,5): pair_i/pair_j stay 2/5 and pair_valid stays 1 for all 3 cycles; the sequence resumes with (2,6) after ready.
- en strobe every 5 cycles (testbench pacing) with N=8:
  - overrun = 1 after the second strobe.
  - The step completes unperturbed with exactly one done pulse.
- N=1 (IDX_W=1): en → upd_valid with upd_idx = 0 at cycle 1, no pair_valid ever, done at cycle 2.
- Reset low during UPDATE of boid 4:
  - All outputs zero in the same cycle; no done pulse.
  - After release, en restarts at pair (0,1); step_count unchanged.
- CNT_W=2: run 5 steps → step_count sequence 1, 2, 3, 0, 1.
